// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// and CLAIM readback layout.
package irq_pkg;

    localparam logic [1:0] IRQ_ADDR_PENDING  = 2'd0;
    localparam logic [1:0] IRQ_ADDR_ENABLE   = 2'd1;
    localparam logic [1:0] IRQ_ADDR_CLAIM    = 2'd2;
    localparam logic [1:0] IRQ_ADDR_COMPLETE = 2'd3;

    localparam int unsigned CLAIM_IN_SERVICE_BIT = 31;
    localparam int unsigned CLAIM_IRQ_BIT        = 30;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        IN_SERVICE
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of req
// (index 0 wins) and whether any bit is set.
module irq_prio_enc #(
    parameter int NUM_SOURCES = 8,
    parameter int ID_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic [NUM_SOURCES-1:0] req,
    output logic [ID_W-1:0]        best,
    output logic                   any
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        best = '0;
        any  = 1'b0;
        for (int unsigned i = NUM_SOURCES; i > 0; i--) begin
            if (req[i-1]) begin
                best = ID_W'(i - 1);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, enable mask, prioritized
// request to the CPU and a claim/complete service handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int ID_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   write,
    input  logic [1:0]             addr,
    input  logic [31:0]            data_in,
    output logic [31:0]            data_out,
    output logic                   irq,
    output logic [ID_W-1:0]        irq_id
);

    logic [NUM_SOURCES-1:0] irq_in_q;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] enable;
    logic [NUM_SOURCES-1:0] ready;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] clr_mask;
    logic [ID_W-1:0]        best;
    logic [ID_W-1:0]        service_id;
    logic                   any;
    logic                   armed;

    logic pending_wr;
    logic enable_wr;
    logic claim_wr;
    logic complete_wr;
    logic claim_ok;
    logic complete_ok;
    logic in_service;

    irq_state_t state;
    irq_state_t state_next;

    // Only the low NUM_SOURCES bits carry data; the rest are don't-care.
    logic unused_data;
    assign unused_data = ^data_in;

    assign pending_wr  = write && (addr == IRQ_ADDR_PENDING);
    assign enable_wr   = write && (addr == IRQ_ADDR_ENABLE);
    assign claim_wr    = write && (addr == IRQ_ADDR_CLAIM);
    assign complete_wr = write && (addr == IRQ_ADDR_COMPLETE);

    assign ready = pending & enable;

    // armed stays low for the first cycle after reset so a line that is
    // already high only primes irq_in_q and does not count as an edge.
    assign rise = irq_in & ~irq_in_q & {NUM_SOURCES{armed}};

    irq_prio_enc #(
        .NUM_SOURCES(NUM_SOURCES),
        .ID_W       (ID_W)
    ) u_prio_enc (
        .req (ready),
        .best(best),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_in_q <= '0;
            armed    <= 1'b0;
        end else begin
            irq_in_q <= irq_in;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        clr_mask = '0;
        if (pending_wr) begin
            clr_mask = data_in[NUM_SOURCES-1:0];
        end
        if (claim_ok) begin
            clr_mask[best] = 1'b1;
        end
    end

    // A new edge overrides any clear landing on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            enable     <= '0;
            service_id <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
            if (enable_wr) begin
                enable <= data_in[NUM_SOURCES-1:0];
            end
            if (claim_ok) begin
                service_id <= best;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (claim_ok) begin
                    state_next = IN_SERVICE;
                end else if (!any) begin
                    state_next = IDLE;
                end
            end
            IN_SERVICE: begin
                if (complete_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A claim is only honoured while something is still ready to hand out.
    always_comb begin
        claim_ok    = (state == REQUEST) && any && claim_wr;
        complete_ok = (state == IN_SERVICE) && complete_wr;
        in_service  = (state == IN_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            irq    <= (state_next == REQUEST);
            irq_id <= (state_next == REQUEST) ? best : '0;
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            IRQ_ADDR_PENDING: data_out[NUM_SOURCES-1:0] = pending;
            IRQ_ADDR_ENABLE:  data_out[NUM_SOURCES-1:0] = enable;
            IRQ_ADDR_CLAIM: begin
                data_out[CLAIM_IN_SERVICE_BIT] = in_service;
                data_out[CLAIM_IRQ_BIT]        = irq;
                data_out[ID_W-1:0]             = service_id;
            end
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_irq_controller;

    localparam int N = 8;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         write;
    logic [1:0]   addr;
    logic [31:0]  data_in;
    logic [31:0]  data_out;
    logic         irq;
    logic [2:0]   irq_id;

    int checks = 0;
    int passes = 0;

    irq_controller #(.NUM_SOURCES(N), .ID_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .write   (write),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: pending bits are a plain vector, the service state
    // is two flags, and the request is "something ready and nobody in service".
    bit [31:0] m_pend, m_en, m_prev;
    bit        m_armed, m_svc, m_irq, m_valid;
    int        m_sid, m_id;

    function automatic int lowest(input bit [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        bit [31:0] rdy, rise, clr, pend_n, en_n;
        bit        clm, cmp, svc_n, irq_n;
        int        b, sid_n;
        if (rst) begin
            m_pend <= 0; m_en <= 0; m_prev <= 0; m_armed <= 0;
            m_svc <= 0; m_irq <= 0; m_sid <= 0; m_id <= 0; m_valid <= 1;
        end else begin
            rdy  = m_pend & m_en;
            b    = lowest(rdy);
            rise = (32'(irq_in) & ~m_prev) & (m_armed ? 32'hFFFF_FFFF : 32'h0);
            clm  = write && addr == 2'd2 && m_irq && rdy != 0;
            cmp  = write && addr == 2'd3 && m_svc;
            clr  = (write && addr == 2'd0) ? (data_in & MASK) : 32'h0;
            if (clm) clr[b] = 1'b1;
            pend_n = (m_pend & ~clr) | rise;
            en_n   = (write && addr == 2'd1) ? (data_in & MASK) : m_en;
            svc_n  = m_svc;
            sid_n  = m_sid;
            if (clm) begin svc_n = 1; sid_n = b; end
            if (cmp) svc_n = 0;
            irq_n  = !cmp && !svc_n && rdy != 0;
            m_pend <= pend_n; m_en <= en_n; m_svc <= svc_n; m_sid <= sid_n;
            m_irq  <= irq_n;  m_id <= irq_n ? b : 0;
            m_prev <= 32'(irq_in); m_armed <= 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_do;
        if (m_valid) begin
            case (addr)
                2'd0: exp_do = m_pend;
                2'd1: exp_do = m_en;
                2'd2: exp_do = {m_svc, m_irq, 27'b0, 3'(m_sid)};
                default: exp_do = 32'h0;
            endcase
            check("model_irq", 32'(irq), 32'(m_irq));
            check("model_irq_id", 32'(irq_id), 32'(m_id));
            check("model_data_out", data_out, exp_do);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; data_in = d;
        cyc();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = data_out;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; irq_in = '0; write = 1'b0; addr = 2'd0; data_in = '0;
        cyc(); cyc();
        rst = 1'b0;
        check("reset_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("reset_read", v, 32'h0);
        end

        // Single pulse on source 0: request two edges later.
        wr(2'd1, 32'h01);
        irq_in = 8'h01; cyc(); irq_in = '0;
        check("t1_irq_latency1", 32'(irq), 32'h0);
        cyc();
        check("t1_irq", 32'(irq), 32'h1);
        check("t1_id", 32'(irq_id), 32'h0);
        wr(2'd2, $urandom);
        check("t1_irq_after_claim", 32'(irq), 32'h0);
        rd(2'd2, v);
        check("t1_claim_read", v, 32'h8000_0000);
        wr(2'd3, $urandom);
        rd(2'd3, v);
        check("t1_complete_read", v, 32'h0);

        // Sources 5 and 2 together: 2 first, then 5 right after completion.
        wr(2'd1, 32'hFF);
        irq_in = 8'h24; cyc(); irq_in = '0; cyc();
        check("t2_irq", 32'(irq), 32'h1);
        check("t2_id2", 32'(irq_id), 32'h2);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);
        check("t2_irq_after_complete", 32'(irq), 32'h0);
        cyc();
        check("t2_irq_again", 32'(irq), 32'h1);
        check("t2_id5", 32'(irq_id), 32'h5);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);

        // Masked source stays quiet, unmasking raises it, W1C withdraws it.
        wr(2'd1, 32'h0);
        irq_in = 8'h08; cyc(); irq_in = '0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("t3_masked", 32'(irq), 32'h0);
        end
        wr(2'd1, 32'h08);
        cyc();
        check("t3_unmasked_irq", 32'(irq), 32'h1);
        check("t3_unmasked_id", 32'(irq_id), 32'h3);
        wr(2'd0, 32'h08);
        cyc();
        check("t3_w1c_irq", 32'(irq), 32'h0);
        rd(2'd0, v);
        check("t3_w1c_pending", v, 32'h0);

        // Held level triggers once; a fresh edge in service is kept for later.
        wr(2'd1, 32'hFF);
        irq_in = 8'h02; cyc(); cyc();
        check("t4_id1", 32'(irq_id), 32'h1);
        wr(2'd2, 32'h0);
        repeat (47) cyc();
        rd(2'd0, v);
        check("t4_held_no_reset", v, 32'h0);
        irq_in = '0; cyc(); irq_in = 8'h02; cyc(); irq_in = '0;
        rd(2'd0, v);
        check("t4_second_edge", v, 32'h02);
        check("t4_no_nesting", 32'(irq), 32'h0);
        wr(2'd3, 32'h0);
        cyc();
        check("t4_rerequest", 32'(irq), 32'h1);
        check("t4_rerequest_id", 32'(irq_id), 32'h1);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);

        // Edge and W1C on the same bit in the same cycle: edge wins.
        wr(2'd1, 32'h0);
        irq_in = 8'h10; write = 1'b1; addr = 2'd0; data_in = 32'h10;
        cyc();
        write = 1'b0;
        rd(2'd0, v);
        check("t5_set_wins", v, 32'h10);
        irq_in = '0;
        wr(2'd0, 32'h10);

        // Reset during service with all lines held high.
        wr(2'd1, 32'hFF);
        irq_in = 8'h01; cyc(); irq_in = '0; cyc();
        wr(2'd2, 32'h0);
        irq_in = 8'hFF; cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check("t6_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("t6_read", v, 32'h0);
        end
        wr(2'd1, 32'hFF);
        cyc(); cyc(); cyc();
        check("t6_no_retrigger", 32'(irq), 32'h0);
        rd(2'd0, v);
        check("t6_pending", v, 32'h0);
        irq_in = '0;

        // Randomized traffic, checked only by the model.
        for (int i = 0; i < 4000; i++) begin
            irq_in  = irq_in ^ N'($urandom & $urandom & $urandom);
            rst     = ($urandom_range(0, 199) == 0);
            write   = ($urandom_range(0, 2) == 0);
            addr    = 2'($urandom_range(0, 3));
            data_in = $urandom;
            cyc();
        end
        rst = 1'b0; write = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sits directly downstream of the timer instances and other peripheral event sources. It collects per-source interrupt lines into rising-edge-latched pending bits and applies an enable mask. It presents one prioritized request to the CPU and tracks a claim/complete service handshake. The CPU talks to it through the same single-cycle `write`/`data_in`/`data_out` register style the timers use, plus a 2-bit register address.

## Interface
- `NUM_SOURCES`, 8 — number of interrupt inputs, legal 1..32; source 0 is highest priority.
- `ID_W`, `$clog2(NUM_SOURCES)` (min 1) — width of source ID.
- `clk` in 1 — system clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `irq_in` in NUM_SOURCES — source lines (e.g. `timer_interrupt` of each timer); level, any duration.
- `write` in 1 — register write strobe, one cycle per access.
- `addr` in 2 — register select: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE.
- `data_in` in 32 — write data.
- `data_out` out 32 — combinational read of register at `addr`.
- `irq` out 1 — request to CPU, registered.
- `irq_id` out ID_W — ID of highest-priority enabled pending source while `irq`=1, registered.

## Operation
- Edge detect: `irq_in_q` holds the previous sample. A source whose line is 1 with `irq_in_q`=0 sets `pending[i]`. A held-high level sets it only once.
- `ready = pending & enable`. `best` = lowest index set in `ready`.
- Register map:
  - PENDING write: write-1-to-clear; bits ≥ NUM_SOURCES are ignored.
  - ENABLE: read/write. Unused bits read 0.
  - CLAIM write: any data value claims. CLAIM read: bit31 = in-service, bit30 = `irq`, [ID_W-1:0] = `service_id`; all other bits 0.
  - COMPLETE write: any data value completes. COMPLETE read: 0.
- FSM states IDLE, REQUEST, IN_SERVICE:
  - IDLE → REQUEST when `ready`≠0.
  - REQUEST → IDLE when `ready`=0, e.g. masked or W1C-cleared before claim.
  - REQUEST + CLAIM write → IN_SERVICE. On this transition `service_id`←`best` and `pending[best]` is cleared.
  - IN_SERVICE + COMPLETE write → IDLE.
- Claim outside REQUEST is ignored. Complete outside IN_SERVICE is ignored.
- New edges keep latching in every state. They are serviced after completion; there is no nesting.
- Simultaneous set and clear of the same pending bit (edge plus W1C, or edge plus claim): set wins, bit stays 1.
- Reset values: `pending`, `enable`, `irq_in_q`, `service_id` = 0; state IDLE; `irq`=0; `irq_id`=0; `data_out` follows reset registers (0 for all addresses).
- Reset mid-service drops the request and discards all pending state. A line still high after reset does not re-trigger, because `irq_in_q` loads the line on the first cycle after reset.

## Timing
- Edge sampled at clock edge t → `pending` set after t → state REQUEST and `irq`=1 after edge t+1. Latency from `irq_in` high to `irq` high is 2 cycles.
- In REQUEST, `irq_id` re-registers `best` each cycle, so a higher-priority arrival updates it 1 cycle after its pending bit sets.
- CLAIM write at edge t → `irq`=0 after t.
- COMPLETE at edge t with `ready`≠0 → `irq`=1 again after edge t+1.
- Masking via ENABLE in REQUEST → `irq`=0 one cycle after the ENABLE write takes effect.
- `data_out` reflects register writes on the cycle after the write edge.

## Structure
- Shared package `irq_pkg`:
  - register address constants `IRQ_ADDR_PENDING/ENABLE/CLAIM/COMPLETE`;
  - state enum `irq_state_t`;
  - CLAIM readback bit positions.
- One sub-module `irq_prio_enc` (parameterized by NUM_SOURCES): combinational lowest-index priority encoder that outputs `best` and `any`.

## Test plan
- Reset, ENABLE=0x01, pulse `irq_in[0]` for 1 cycle → `irq`=1 exactly 2 cycles later with `irq_id`=0; CLAIM → `irq`=0, CLAIM read = 0x80000000; COMPLETE → read 0.
- ENABLE=0xFF, raise sources 5 and 2 on the same cycle → `irq_id`=2. After claim and complete, `irq` rises again 1 cycle after COMPLETE with `irq_id`=5.
- Source 3 pending, ENABLE=0 → `irq` stays 0 for 100 cycles. Write ENABLE=0x08 → `irq`=1 next cycle. W1C PENDING=0x08 before claim → `irq`=0, state IDLE.
- Hold `irq_in[1]` high 50 cycles with enable set, claim it → pending bit 1 does not re-set; a second rising edge during IN_SERVICE re-sets it, and it is re-requested after COMPLETE.
- Edge on source 4 in the same cycle as W1C of bit 4 → PENDING reads 0x10 afterwards.
- Assert `rst` for 1 cycle while IN_SERVICE with `irq_in`=0xFF held → all reads 0 and `irq`=0; no new request without a fresh rising edge, even after ENABLE=0xFF.
